// File: rtl/mbist_mem_if.sv
// Port bundle between the March C- controller (master) and the single-port memory under test (slave).
interface mbist_mem_if #(
  parameter int a_width = 4,
  parameter int width   = 4
);
  logic               mem_read;
  logic               mem_write;
  logic [a_width-1:0] mem_address;
  logic [width-1:0]   mem_data_in;
  logic [width-1:0]   mem_data_out;

  modport master (
    output mem_read, mem_write, mem_address, mem_data_in,
    input  mem_data_out
  );

  modport slave (
    input  mem_read, mem_write, mem_address, mem_data_in,
    output mem_data_out
  );
endinterface

// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST controller with registered memory ports and first-fail diagnostics.
// MBIST_CHECKERBOARD_EN: when defined, a second M0..M5 pass runs on a checkerboard background.
module mbist_march_ctrl #(
  parameter int a_width = 4,
  parameter int width   = 4,
  parameter int depth   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  mbist_mem_if.master        mem,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic [a_width-1:0] fail_address,
  output logic [width-1:0]   fail_expected,
  output logic [width-1:0]   fail_actual
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_CHECK = 2'd2,
    S_END   = 2'd3
  } state_t;

  localparam logic [a_width-1:0] addr_top  = a_width'(depth - 1);
  localparam logic [a_width-1:0] addr_zero = {a_width{1'b0}};
  localparam logic [a_width-1:0] addr_one  = a_width'(1);

`ifdef MBIST_CHECKERBOARD_EN
  localparam logic [3:0] last_elem = 4'd11;

  function automatic logic [width-1:0] checker_word();
    logic [width-1:0] w;
    for (int i = 0; i < width; i++) begin
      w[i] = 1'(i % 2);
    end
    return w;
  endfunction
`else
  localparam logic [3:0] last_elem = 4'd5;
`endif

  state_t             state_r, state_n;
  logic [3:0]         elem_r;
  logic [3:0]         step_s;
  logic [a_width-1:0] addr_r;
  logic               phase_r;
  logic               issued_r;

  logic               op_write_s, op_flip_s, two_op_s, down_s, next_down_s;
  logic               elem_last_s, all_last_s;
  logic [width-1:0]   bg0_s, op_data_s;
  logic               launch_s, issue_s, mismatch_s;

  logic               mem_read_r, mem_write_r;
  logic [a_width-1:0] mem_addr_r;
  logic [width-1:0]   mem_din_r, mem_exp_r;
  logic               rd_pend_r;
  logic [a_width-1:0] cmp_addr_r;
  logic [width-1:0]   cmp_exp_r;

  logic               busy_r, done_r, fail_r;
  logic [a_width-1:0] fail_addr_r;
  logic [width-1:0]   fail_exp_r, fail_act_r;

`ifdef MBIST_CHECKERBOARD_EN
  assign step_s = (elem_r >= 4'd6) ? (elem_r - 4'd6) : elem_r;
  assign bg0_s  = (elem_r >= 4'd6) ? checker_word() : {width{1'b0}};
`else
  assign step_s = elem_r;
  assign bg0_s  = {width{1'b0}};
`endif

  // The read of cycle N is judged against the data the memory registers for cycle N+1.
  assign mismatch_s = rd_pend_r && (mem.mem_data_out != cmp_exp_r);
  assign launch_s   = ((state_r == S_IDLE) || (state_r == S_END)) && start;
  assign issue_s    = (state_r == S_RUN) && !issued_r && !mismatch_s;

  // Decode the current March element step into operation, data polarity and direction.
  always_comb begin
    op_write_s = 1'b0;
    op_flip_s  = 1'b0;
    two_op_s   = 1'b1;
    down_s     = 1'b0;
    case (step_s)
      4'd0: begin op_write_s = 1'b1; two_op_s = 1'b0; end
      4'd1: begin op_write_s = phase_r; op_flip_s = phase_r; end
      4'd2: begin op_write_s = phase_r; op_flip_s = ~phase_r; end
      4'd3: begin op_write_s = phase_r; op_flip_s = phase_r; down_s = 1'b1; end
      4'd4: begin op_write_s = phase_r; op_flip_s = ~phase_r; down_s = 1'b1; end
      4'd5: begin two_op_s = 1'b0; end
      default: begin two_op_s = 1'b0; end
    endcase
    op_data_s   = bg0_s ^ {width{op_flip_s}};
    next_down_s = (step_s == 4'd2) || (step_s == 4'd3);
    elem_last_s = (!two_op_s || phase_r) &&
                  (down_s ? (addr_r == addr_zero) : (addr_r == addr_top));
    all_last_s  = elem_last_s && (elem_r == last_elem);
  end

  // Next-state selection.
  always_comb begin
    state_n = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_n = S_RUN;
        else       state_n = S_IDLE;
      end
      S_RUN: begin
        if (mismatch_s)    state_n = S_END;
        else if (issued_r) state_n = S_CHECK;
        else               state_n = S_RUN;
      end
      S_CHECK: state_n = S_END;
      S_END: begin
        if (start) state_n = S_RUN;
        else       state_n = S_END;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= S_IDLE;
    else        state_r <= state_n;
  end

  // Element/address/phase sequencer; the address reloads at each element boundary.
  always_ff @(posedge clk) begin
    if (!rst_n || launch_s) begin
      elem_r   <= 4'd0;
      addr_r   <= addr_zero;
      phase_r  <= 1'b0;
      issued_r <= 1'b0;
    end else if (issue_s) begin
      if (two_op_s && !phase_r) begin
        phase_r <= 1'b1;
      end else begin
        phase_r <= 1'b0;
        if (elem_last_s) begin
          elem_r <= elem_r + 4'd1;
          addr_r <= next_down_s ? addr_top : addr_zero;
        end else begin
          addr_r <= down_s ? (addr_r - addr_one) : (addr_r + addr_one);
        end
      end
      if (all_last_s) issued_r <= 1'b1;
    end
  end

  // Registered memory port drive; silenced from the mismatch edge onward.
  always_ff @(posedge clk) begin
    if (!rst_n || !issue_s) begin
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
      mem_addr_r  <= addr_zero;
      mem_din_r   <= {width{1'b0}};
      mem_exp_r   <= {width{1'b0}};
    end else begin
      mem_read_r  <= ~op_write_s;
      mem_write_r <= op_write_s;
      mem_addr_r  <= addr_r;
      mem_din_r   <= op_write_s ? op_data_s : {width{1'b0}};
      mem_exp_r   <= op_data_s;
    end
  end

  // Compare pipeline stage aligned with the memory's registered read data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_pend_r  <= 1'b0;
      cmp_addr_r <= addr_zero;
      cmp_exp_r  <= {width{1'b0}};
    end else begin
      rd_pend_r  <= mem_read_r && (state_r == S_RUN) && !mismatch_s;
      cmp_addr_r <= mem_addr_r;
      cmp_exp_r  <= mem_exp_r;
    end
  end

  // Status and first-fail capture.
  always_ff @(posedge clk) begin
    if (!rst_n || launch_s) begin
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      fail_r      <= 1'b0;
      fail_addr_r <= addr_zero;
      fail_exp_r  <= {width{1'b0}};
      fail_act_r  <= {width{1'b0}};
    end else begin
      busy_r <= (state_r == S_RUN) && !mismatch_s;
      if (mismatch_s) begin
        done_r      <= 1'b1;
        fail_r      <= 1'b1;
        fail_addr_r <= cmp_addr_r;
        fail_exp_r  <= cmp_exp_r;
        fail_act_r  <= mem.mem_data_out;
      end else if (state_r == S_CHECK) begin
        done_r <= 1'b1;
      end else begin
        done_r <= done_r;
      end
    end
  end

  assign mem.mem_read    = mem_read_r;
  assign mem.mem_write   = mem_write_r;
  assign mem.mem_address = mem_addr_r;
  assign mem.mem_data_in = mem_din_r;
  assign busy            = busy_r;
  assign done            = done_r;
  assign fail            = fail_r;
  assign fail_address    = fail_addr_r;
  assign fail_expected   = fail_exp_r;
  assign fail_actual     = fail_act_r;

endmodule
